// File: rtl/regfile_wr_sched_pkg.sv
// Shared types and helpers for the register-file write-port scheduler.
package regfile_pkg;

    typedef enum logic {INIT, RUN} state_t;

    // Default register-file geometry; instances override LO/HI as parameters.
    localparam int DEF_LO      = 0;
    localparam int DEF_HI      = 31;
    localparam int NUM_ENTRIES = DEF_HI - DEF_LO + 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic logic in_range(input int addr, input int lo, input int hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/regfile_wr_sched_if.sv
// Requester-side write bus: per-requester valid/ready plus packed address and data.
interface regfile_wr_sched_if #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;

    modport master (output req_valid, output req_addr, output req_data, input req_ready);
    modport slave  (input req_valid, input req_addr, input req_data, output req_ready);
endinterface

// File: rtl/regfile_wr_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the rotating pointer.
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [N-1:0]          req,
    input  logic                  advance,
    output logic [N-1:0]          gnt,
    output logic [clog2(N)-1:0]   gnt_idx
);
    localparam int W = clog2(N);

    logic [W-1:0] ptr;
    int unsigned  idx;
    logic         found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        idx     = 0;
        found   = 1'b0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = 32'(ptr) + off;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = W'(idx);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (gnt_idx == W'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wr_sched.sv
// Register-file write-port scheduler: init sweep after reset, then round-robin
// sharing of the single write port with out-of-range write filtering.
module regfile_wr_sched
    import regfile_pkg::*;
#(
    parameter int              NREQ     = 4,
    parameter int              ADDR_W   = 5,
    parameter int              DATA_W   = 32,
    parameter int              LO       = 0,
    parameter int              HI       = 31,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                     CLK,
    input  logic                     RST,
    regfile_wr_sched_if.slave        req,
    output logic [ADDR_W-1:0]        rf_addr,
    output logic [DATA_W-1:0]        rf_data,
    output logic                     rf_we,
    output logic                     init_busy,
    output logic                     oob_err,
    output logic [clog2(NREQ)-1:0]   oob_idx,
    input  logic                     err_clr
);
    localparam int IDX_W = clog2(NREQ);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [NREQ-1:0]   gnt, ready;
    logic [IDX_W-1:0]  gnt_idx;
    logic              accept, sel_ok;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    rr_arbiter #(.N(NREQ)) u_arb (
        .CLK     (CLK),
        .RST     (RST),
        .req     (req.req_valid),
        .advance (accept),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign sel_addr      = req.req_addr[gnt_idx*ADDR_W +: ADDR_W];
    assign sel_data      = req.req_data[gnt_idx*DATA_W +: DATA_W];
    assign sel_ok        = in_range(32'(sel_addr), LO, HI);
    assign accept        = |ready;
    assign req.req_ready = ready;

    always_ff @(posedge CLK) begin
        if (RST) state <= INIT;
        else     state <= state_nxt;
    end

    // Ready is gated by RST directly so it drops in the reset cycle itself.
    always_comb begin
        state_nxt = state;
        ready     = '0;
        init_busy = 1'b0;
        case (state)
            INIT: begin
                init_busy = 1'b1;
                if (ptr == ADDR_W'(HI)) state_nxt = RUN;
            end
            RUN: begin
                if (!RST) ready = gnt & req.req_valid;
            end
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr     <= ADDR_W'(LO);
            rf_we   <= 1'b0;
            rf_addr <= ADDR_W'(LO);
            rf_data <= '0;
            oob_err <= 1'b0;
            oob_idx <= '0;
        end else begin
            case (state)
                INIT: begin
                    rf_we   <= 1'b1;
                    rf_addr <= ptr;
                    rf_data <= INIT_VAL;
                    ptr     <= ptr + 1'b1;
                end
                RUN: begin
                    rf_we <= accept && sel_ok;
                    if (accept && sel_ok) begin
                        rf_addr <= sel_addr;
                        rf_data <= sel_data;
                    end
                    // A dropped write in the same cycle as err_clr keeps the flag set.
                    if (accept && !sel_ok) begin
                        oob_err <= 1'b1;
                        oob_idx <= gnt_idx;
                    end else if (err_clr) begin
                        oob_err <= 1'b0;
                    end
                end
                default: rf_we <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Directed bench: sweep, single write, round-robin, reset mid-run, out-of-range handling.
module tb_regfile_wr_sched;
    localparam int NREQ   = 4;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam logic [31:0] A5 = 32'hA5A5A5A5;

    logic CLK = 1'b0;
    logic RST, RSTb, err_clr_a, err_clr_b;

    logic [ADDR_W-1:0] rf_addr_a, rf_addr_b;
    logic [DATA_W-1:0] rf_data_a, rf_data_b;
    logic              rf_we_a, rf_we_b, busy_a, busy_b, oob_a, oob_b;
    logic [1:0]        oob_idx_a, oob_idx_b;

    int n_cmp = 0;
    int n_err = 0;

    regfile_wr_sched_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) a_if ();
    regfile_wr_sched_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) b_if ();

    regfile_wr_sched #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                       .LO(0), .HI(31), .INIT_VAL(A5)) dut_a (
        .CLK(CLK), .RST(RST), .req(a_if.slave),
        .rf_addr(rf_addr_a), .rf_data(rf_data_a), .rf_we(rf_we_a),
        .init_busy(busy_a), .oob_err(oob_a), .oob_idx(oob_idx_a), .err_clr(err_clr_a)
    );

    regfile_wr_sched #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                       .LO(4), .HI(27), .INIT_VAL(32'h0)) dut_b (
        .CLK(CLK), .RST(RSTb), .req(b_if.slave),
        .rf_addr(rf_addr_b), .rf_data(rf_data_b), .rf_we(rf_we_b),
        .init_busy(busy_b), .oob_err(oob_b), .oob_idx(oob_idx_b), .err_clr(err_clr_b)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expects 32 consecutive init writes on dut_a, starting at the next edge.
    task automatic sweep_a();
        for (int k = 0; k < 32; k++) begin
            tick();
            chk("sweep_we",   64'(rf_we_a),   64'(1));
            chk("sweep_addr", 64'(rf_addr_a), 64'(k));
            chk("sweep_data", 64'(rf_data_a), 64'(A5));
            if (k < 31) begin
                chk("sweep_busy",  64'(busy_a),         64'(1));
                chk("sweep_ready", 64'(a_if.req_ready), 64'(0));
            end else begin
                chk("sweep_busy_fall", 64'(busy_a), 64'(0));
            end
        end
    endtask

    int exp_g [12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2, 3, 0};

    initial begin
        RST = 1'b1; RSTb = 1'b1; err_clr_a = 1'b0; err_clr_b = 1'b0;
        a_if.req_valid = '1;
        b_if.req_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            a_if.req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(8 + i);
            a_if.req_data[i*DATA_W +: DATA_W] = 32'h1000_0000 + i;
            b_if.req_addr[i*ADDR_W +: ADDR_W] = '0;
            b_if.req_data[i*DATA_W +: DATA_W] = '0;
        end

        tick(); tick();
        chk("rst_we",      64'(rf_we_a),        64'(0));
        chk("rst_addr",    64'(rf_addr_a),      64'(0));
        chk("rst_data",    64'(rf_data_a),      64'(0));
        chk("rst_busy",    64'(busy_a),         64'(1));
        chk("rst_oob",     64'(oob_a),          64'(0));
        chk("rst_oob_idx", 64'(oob_idx_a),      64'(0));
        chk("rst_ready",   64'(a_if.req_ready), 64'(0));
        chk("rst_addr_b",  64'(rf_addr_b),      64'(4));
        chk("rst_oob_b",   64'(oob_b),          64'(0));
        RST = 1'b0; RSTb = 1'b0;

        sweep_a();

        // Round-robin with all valid, then requester 1 drops out.
        for (int j = 0; j < 12; j++) begin
            if (j == 6) begin
                a_if.req_valid = 4'b1101;
                #1;
            end
            chk("rr_ready", 64'(a_if.req_ready), 64'(1) << exp_g[j]);
            tick();
            chk("rr_we",   64'(rf_we_a),   64'(1));
            chk("rr_addr", 64'(rf_addr_a), 64'(8 + exp_g[j]));
            chk("rr_data", 64'(rf_data_a), 64'(32'h1000_0000 + exp_g[j]));
        end

        // Single requester 2.
        a_if.req_valid = 4'b0100;
        a_if.req_addr[2*ADDR_W +: ADDR_W] = 5'd5;
        a_if.req_data[2*DATA_W +: DATA_W] = 32'hDEADBEEF;
        #1;
        chk("single_ready", 64'(a_if.req_ready), 64'(4'b0100));
        tick();
        a_if.req_valid = '0;
        chk("single_we",   64'(rf_we_a),   64'(1));
        chk("single_addr", 64'(rf_addr_a), 64'(5));
        chk("single_data", 64'(rf_data_a), 64'(32'hDEADBEEF));
        tick();
        chk("single_idle", 64'(rf_we_a), 64'(0));

        // Reset while all requesters stream.
        a_if.req_addr[2*ADDR_W +: ADDR_W] = 5'd10;
        a_if.req_data[2*DATA_W +: DATA_W] = 32'h1000_0002;
        a_if.req_valid = '1;
        tick(); tick();
        RST = 1'b1;
        #1;
        chk("mid_rst_ready", 64'(a_if.req_ready), 64'(0));
        tick();
        RST = 1'b0;
        chk("mid_rst_we",    64'(rf_we_a),        64'(0));
        chk("mid_rst_busy",  64'(busy_a),         64'(1));
        chk("mid_rst_ready2", 64'(a_if.req_ready), 64'(0));
        sweep_a();
        chk("mid_rst_first_grant", 64'(a_if.req_ready), 64'(4'b0001));
        a_if.req_valid = '0;

        // Out-of-range handling on dut_b (LO=4, HI=27).
        b_if.req_valid = 4'b1000;
        b_if.req_addr[3*ADDR_W +: ADDR_W] = 5'd30;
        #1;
        chk("oob_ready", 64'(b_if.req_ready), 64'(4'b1000));
        tick();
        b_if.req_valid = '0;
        chk("oob_we",  64'(rf_we_b),   64'(0));
        chk("oob_err", 64'(oob_b),     64'(1));
        chk("oob_idx", 64'(oob_idx_b), 64'(3));
        err_clr_b = 1'b1;
        tick();
        err_clr_b = 1'b0;
        chk("oob_clr", 64'(oob_b), 64'(0));

        b_if.req_valid = 4'b0001;
        b_if.req_addr[0 +: ADDR_W] = 5'd4;
        b_if.req_data[0 +: DATA_W] = 32'h44;
        tick();
        b_if.req_valid = '0;
        chk("lo_we",   64'(rf_we_b),   64'(1));
        chk("lo_addr", 64'(rf_addr_b), 64'(4));
        chk("lo_data", 64'(rf_data_b), 64'(32'h44));

        b_if.req_valid = 4'b0010;
        b_if.req_addr[1*ADDR_W +: ADDR_W] = 5'd27;
        b_if.req_data[1*DATA_W +: DATA_W] = 32'h27;
        tick();
        b_if.req_valid = '0;
        chk("hi_we",   64'(rf_we_b),   64'(1));
        chk("hi_addr", 64'(rf_addr_b), 64'(27));

        b_if.req_valid = 4'b1000;
        tick();
        b_if.req_valid = '0;
        chk("oob2_err", 64'(oob_b), 64'(1));

        b_if.req_valid = 4'b0010;
        b_if.req_addr[1*ADDR_W +: ADDR_W] = 5'd3;
        err_clr_b = 1'b1;
        #1;
        chk("oob3_ready", 64'(b_if.req_ready), 64'(4'b0010));
        tick();
        b_if.req_valid = '0;
        err_clr_b = 1'b0;
        chk("set_wins_err", 64'(oob_b),     64'(1));
        chk("set_wins_idx", 64'(oob_idx_b), 64'(1));
        chk("set_wins_we",  64'(rf_we_b),   64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
